// File: rtl/seq_restoring_divider_if.sv
// Handshake bundle for seq_restoring_divider.
// Requester drives master, divider takes slave.
interface seq_restoring_divider_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider, one iteration per clock.
// Define DIVIDER_SIGNED_EN for two's complement operands.
module seq_restoring_divider #(
   parameter int WIDTH = 8
) (
   input logic                    CLOCK_50,
   input logic                    reset,
   seq_restoring_divider_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH:0]   a_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] m_reg;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   logic [WIDTH:0]   a_sh;
   logic [WIDTH-1:0] q_sh;
   logic [WIDTH:0]   diff;
   logic [WIDTH:0]   a_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic             last;
   logic             dvs_zero;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH-1:0] q_res;
   logic [WIDTH-1:0] r_res;

   assign dvs_zero = (bus.divisor == '0);
   assign last     = (count == CW'(WIDTH - 1));

`ifdef DIVIDER_SIGNED_EN
   logic neg_q;
   logic neg_r;

   assign dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
   assign dvs_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
   assign q_res   = neg_q ? -q_nxt : q_nxt;
   assign r_res   = neg_r ? -a_nxt[WIDTH-1:0] : a_nxt[WIDTH-1:0];

   // Remember result signs from the operands at acceptance
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (state == S_IDLE && bus.start) begin
         neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
         neg_r <= bus.dividend[WIDTH-1];
      end
   end
`else
   assign dvd_mag = bus.dividend;
   assign dvs_mag = bus.divisor;
   assign q_res   = q_nxt;
   assign r_res   = a_nxt[WIDTH-1:0];
`endif

   // One shift/subtract/restore step on {A,Q}
   always_comb begin
      a_sh  = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
      q_sh  = {q_reg[WIDTH-2:0], 1'b0};
      diff  = a_sh - {1'b0, m_reg};
      a_nxt = a_sh;
      q_nxt = q_sh;
      if (!diff[WIDTH]) begin
         a_nxt = diff;
         q_nxt = q_sh | WIDTH'(1);
      end
   end

   // State register
   always_ff @(posedge CLOCK_50) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state: zero divisor skips straight to DONE
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (bus.start)
               state_nxt = dvs_zero ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (last) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand capture, iteration and result registers
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         a_reg       <= '0;
         q_reg       <= '0;
         m_reg       <= '0;
         count       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.start) begin
                  a_reg <= '0;
                  q_reg <= dvd_mag;
                  m_reg <= dvs_mag;
                  count <= '0;
                  if (dvs_zero) begin
                     quotient    <= '1;
                     remainder   <= bus.dividend;
                     div_by_zero <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               a_reg <= a_nxt;
               q_reg <= q_nxt;
               count <= count + 1'b1;
               if (last) begin
                  quotient    <= q_res;
                  remainder   <= r_res;
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = (state == S_RUN);
   assign bus.done        = (state == S_DONE);
   assign bus.quotient    = quotient;
   assign bus.remainder   = remainder;
   assign bus.div_by_zero = div_by_zero;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider, WIDTH=8.
// Signed vectors run only with DIVIDER_SIGNED_EN.
module tb_seq_restoring_divider;
   logic clk;
   logic reset;
   int   n_chk;
   int   n_err;

   seq_restoring_divider_if #(.WIDTH(8)) bus ();

   seq_restoring_divider #(.WIDTH(8)) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] eq,
                         input logic [7:0] er, input logic edbz,
                         input int elat);
      int n;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.dividend = 8'hAA;
      bus.divisor  = 8'h00;
      n = 1;
      if (elat > 1) chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      while (!bus.done && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'(elat));
      chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
      chk({tag, "_q"}, 32'(bus.quotient), 32'(eq));
      chk({tag, "_r"}, 32'(bus.remainder), 32'(er));
      chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(edbz));
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
      chk({tag, "_hold"}, 32'(bus.quotient), 32'(eq));
   endtask

   initial begin
      int nd;
      int last_i;
      n_chk        = 0;
      n_err        = 0;
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_q", 32'(bus.quotient), 32'd0);
      chk("rst_r", 32'(bus.remainder), 32'd0);
      chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      run_op("200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9);
      run_op("5_0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1);
      run_op("9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9);
      run_op("255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
      run_op("0_3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 9);
      run_op("3_200", 8'd3, 8'd200, 8'd0, 8'd3, 1'b0, 9);

      // start held high: one result every 10 cycles
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 8'd100;
      bus.divisor  = 8'd9;
      nd     = 0;
      last_i = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            nd++;
            chk("hold_q", 32'(bus.quotient), 32'd11);
            chk("hold_r", 32'(bus.remainder), 32'd1);
            if (nd > 1) chk("hold_period", 32'(i - last_i), 32'd10);
            last_i = i;
         end
      end
      bus.start = 1'b0;
      chk("hold_count", 32'(nd), 32'd3);
      repeat (2) @(posedge clk);
      #1;

      // start pulses in RUN and DONE are ignored
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 8'd200;
      bus.divisor  = 8'd7;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      nd = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         bus.start = (i == 3 || i == 9);
         @(posedge clk);
         #1;
         if (bus.done) nd++;
      end
      bus.start = 1'b0;
      chk("pulse_count", 32'(nd), 32'd1);
      chk("pulse_q", 32'(bus.quotient), 32'd28);

      // reset mid-operation discards it
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 8'd200;
      bus.divisor  = 8'd7;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("mrst_busy", 32'(bus.busy), 32'd0);
      chk("mrst_done", 32'(bus.done), 32'd0);
      chk("mrst_q", 32'(bus.quotient), 32'd0);
      chk("mrst_r", 32'(bus.remainder), 32'd0);
      nd = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) nd++;
      end
      chk("mrst_nodone", 32'(nd), 32'd0);

`ifdef DIVIDER_SIGNED_EN
      run_op("s_m7_2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 9);
      run_op("s_7_m2", 8'd7, 8'hFE, 8'hFD, 8'd1, 1'b0, 9);
      run_op("s_min_m1", 8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, 9);
      run_op("s_m5_0", 8'hFB, 8'd0, 8'hFF, 8'hFB, 1'b1, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
